// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for register_file: fixed-priority writeback plus a FIFO-buffered host requester.
// Optional post-reset zero sweep of the 16 scalar registers is enabled with `define REGFILE_ARB_CLEAR_EN.
module regfile_write_arbiter #(
   parameter int N            = 32,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wb_we,
   input  logic [4:0]   wb_a3,
   input  logic [N-1:0] wb_wd3,
   input  logic         host_valid,
   output logic         host_ready,
   input  logic [4:0]   host_a3,
   input  logic [N-1:0] host_wd3,
   output logic         host_err,
   output logic         starve,
   output logic         busy,
   output logic         WE3,
   output logic [4:0]   A3,
   output logic [N-1:0] WD3
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(STARVE_LIMIT + 1);
   localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
   localparam logic [WW-1:0] WAIT_MAX   = STARVE_LIMIT[WW-1:0];

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

`ifdef REGFILE_ARB_CLEAR_EN
   localparam state_t RESET_STATE = CLEAR;
`else
   localparam state_t RESET_STATE = RUN;
`endif

   state_t          state;
   state_t          state_next;
   logic [3:0]      sweep_cnt;
   logic [4:0]      fifo_a3  [DEPTH];
   logic [N-1:0]    fifo_wd3 [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic [WW-1:0]   wait_cnt;
   logic [WW-1:0]   wait_next;
   logic            run;
   logic            fifo_empty;
   logic            host_bad;
   logic            accept;
   logic            push;
   logic            pop;

   assign run        = (state == RUN);
   assign fifo_empty = (count == '0);

   // $zero, $pc and the vector file are not legal host targets; they still handshake.
   assign host_bad   = host_a3[4] || (host_a3 == 5'd0) || (host_a3 == 5'd15);
   assign host_ready = run && (count != FULL_COUNT) && rst;
   assign accept     = host_valid && host_ready;
   assign push       = accept && !host_bad;
   assign pop        = run && !wb_we && !fifo_empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RESET_STATE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if ((state == CLEAR) && (sweep_cnt == 4'd15)) begin
         state_next = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sweep_cnt <= '0;
      end else if (state == CLEAR) begin
         sweep_cnt <= sweep_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a3[wr_ptr]  <= host_a3;
         fifo_wd3[wr_ptr] <= host_wd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Writeback always wins the port; the host head only takes otherwise idle slots.
   always_ff @(posedge clk) begin
      if (!rst) begin
         WE3 <= 1'b0;
         A3  <= '0;
         WD3 <= '0;
      end else if (state == CLEAR) begin
         WE3 <= 1'b1;
         A3  <= {1'b0, sweep_cnt};
         WD3 <= '0;
      end else if (wb_we) begin
         WE3 <= 1'b1;
         A3  <= wb_a3;
         WD3 <= wb_wd3;
      end else if (pop) begin
         WE3 <= 1'b1;
         A3  <= fifo_a3[rd_ptr];
         WD3 <= fifo_wd3[rd_ptr];
      end else begin
         WE3 <= 1'b0;
      end
   end

   always_comb begin
      wait_next = '0;
      if (run && !fifo_empty && wb_we) begin
         wait_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt <= '0;
         starve   <= 1'b0;
         host_err <= 1'b0;
      end else begin
         wait_cnt <= wait_next;
         starve   <= (wait_next >= WAIT_MAX);
         host_err <= accept && host_bad;
      end
   end

`ifdef REGFILE_ARB_CLEAR_EN
   logic busy_q;

   // Stays high through the cycle that shows the final (register 15) sweep write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q <= 1'b1;
      end else begin
         busy_q <= (state == CLEAR);
      end
   end

   assign busy = busy_q;
`else
   assign busy = 1'b0;
`endif

endmodule
